// File: rtl/ccr_flag_sequencer_pkg.sv
// Shared opcode, flag and sequencer-state definitions for the CCR flag sequencer.
// Opcode values follow the ALU decoder encoding.
package ccr_flag_sequencer_pkg;

    localparam int CCR_W = 3;

    localparam int OP_SETC  = 2;
    localparam int OP_CLRC  = 3;
    localparam int OP_JZ    = 20;
    localparam int OP_JN    = 21;
    localparam int OP_JC    = 22;
    localparam int OP_RTI   = 26;
    localparam int OP_RESET = 27;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SAVE  = 2'd2,
        ST_ACK   = 2'd3
    } seq_state_e;

    // One-hot mask of the flag tested by a conditional branch; zero for non-branches.
    function automatic logic [CCR_W-1:0] branch_mask(input int op);
        logic [CCR_W-1:0] m;
        m = '0;
        case (op)
            OP_JZ:   m[FLAG_Z] = 1'b1;
            OP_JN:   m[FLAG_N] = 1'b1;
            OP_JC:   m[FLAG_C] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ccr_stack.sv
// Saturating LIFO of saved CCR values used for interrupt entry and RTI restore.
// Pushes when full and pops when empty are ignored; the caller flags the error.
module ccr_stack
    import ccr_flag_sequencer_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [CCR_W-1:0] din,
    output logic [CCR_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int PW = AW + 1;

    logic [CCR_W-1:0] mem [STACK_DEPTH];
    logic [PW-1:0]    sp;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign full   = (sp == PW'(STACK_DEPTH));
    assign empty  = (sp == '0);
    assign wr_idx = sp[AW-1:0];
    assign rd_idx = sp[AW-1:0] - AW'(1);
    assign dout   = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (clr) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PW'(1);
        end else if (pop && !empty) begin
            sp <= sp - PW'(1);
        end
    end

    // Storage carries no reset; the pointer alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/ccr_flag_sequencer.sv
// Execute-stage condition-code register with branch resolution, interrupt entry
// sequencing (drain, save, acknowledge) and RTI restore through a private CCR stack.
module ccr_flag_sequencer
    import ccr_flag_sequencer_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int OP_W        = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [OP_W-1:0] alu_op_i,
    input  logic [2:0]      alu_flags_i,
    input  logic            alu_flags_we_i,
    input  logic            int_req_i,
    output logic [2:0]      ccr_o,
    output logic            jump_taken_o,
    output logic            stall_o,
    output logic            int_ack_o,
    output logic            err_o
);

    seq_state_e       state_q, state_d;
    logic [CCR_W-1:0] ccr_q, ccr_d;
    logic             jump_q, jump_d;
    logic             err_q, err_d;

    logic             accept;
    int               op_val;
    logic [CCR_W-1:0] br_mask;

    logic             stk_push, stk_pop, stk_clr;
    logic [CCR_W-1:0] stk_dout;
    logic             stk_full, stk_empty;

    assign stall_o      = (state_q != ST_IDLE);
    assign int_ack_o    = (state_q == ST_ACK);
    assign ccr_o        = ccr_q;
    assign jump_taken_o = jump_q;
    assign err_o        = err_q;

    assign accept  = valid_i && (state_q == ST_IDLE);
    assign op_val  = int'(alu_op_i);
    assign br_mask = branch_mask(op_val);

    ccr_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .clr   (stk_clr),
        .din   (ccr_q),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        ccr_d    = ccr_q;
        jump_d   = 1'b0;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (int_req_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_SAVE;
            end
            ST_SAVE: begin
                // A full stack drops the save but the handler still starts from a clean CCR.
                if (stk_full) begin
                    err_d = 1'b1;
                end else begin
                    stk_push = 1'b1;
                end
                ccr_d   = '0;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only reachable in IDLE, so it never collides with the SAVE-state CCR clear.
        if (accept) begin
            case (op_val)
                OP_SETC: begin
                    ccr_d[FLAG_C] = 1'b1;
                end
                OP_CLRC: begin
                    ccr_d[FLAG_C] = 1'b0;
                end
                OP_JZ, OP_JN, OP_JC: begin
                    if ((ccr_q & br_mask) != '0) begin
                        jump_d = 1'b1;
                        ccr_d  = ccr_q & ~br_mask;
                    end
                end
                OP_RTI: begin
                    if (stk_empty) begin
                        err_d = 1'b1;
                    end else begin
                        stk_pop = 1'b1;
                        ccr_d   = stk_dout;
                    end
                end
                OP_RESET: begin
                    ccr_d   = '0;
                    stk_clr = 1'b1;
                end
                default: begin
                    if (alu_flags_we_i) begin
                        ccr_d = alu_flags_i;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ccr_q   <= '0;
            jump_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ccr_q   <= ccr_d;
            jump_q  <= jump_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ccr_flag_sequencer.sv
// Self-checking bench for ccr_flag_sequencer: directed scenarios plus a randomized
// run compared cycle by cycle against a queue-based reference model.
module tb_ccr_flag_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i;
    logic [4:0] alu_op_i;
    logic [2:0] alu_flags_i;
    logic       alu_flags_we_i;
    logic       int_req_i;
    logic [2:0] ccr_o;
    logic       jump_taken_o;
    logic       stall_o;
    logic       int_ack_o;
    logic       err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: CCR, saved-CCR stack, sticky error, interrupt phase.
    logic [2:0] m_ccr;
    logic [2:0] m_stack [$];
    logic       m_err;
    logic       m_jump;
    int         m_phase;

    always #5 clk = ~clk;

    ccr_flag_sequencer #(
        .STACK_DEPTH (DEPTH),
        .OP_W        (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .alu_op_i       (alu_op_i),
        .alu_flags_i    (alu_flags_i),
        .alu_flags_we_i (alu_flags_we_i),
        .int_req_i      (int_req_i),
        .ccr_o          (ccr_o),
        .jump_taken_o   (jump_taken_o),
        .stall_o        (stall_o),
        .int_ack_o      (int_ack_o),
        .err_o          (err_o)
    );

    task automatic model_reset();
        m_ccr   = 3'b000;
        m_stack.delete();
        m_err   = 1'b0;
        m_jump  = 1'b0;
        m_phase = 0;
    endtask

    // phase: 0 idle, 1 drain, 2 save, 3 acknowledge
    task automatic model_step(input logic v, input int op, input logic [2:0] f,
                              input logic we, input logic req);
        bit         accept;
        int         nphase;
        logic [1:0] idx;
        accept = v && (m_phase == 0);
        case (m_phase)
            0:       nphase = req ? 1 : 0;
            1:       nphase = 2;
            2:       nphase = 3;
            default: nphase = 0;
        endcase
        m_jump = 1'b0;
        if (m_phase == 2) begin
            if (m_stack.size() >= DEPTH) m_err = 1'b1;
            else m_stack.push_back(m_ccr);
            m_ccr = 3'b000;
        end
        if (accept) begin
            if (op == 2) m_ccr[2] = 1'b1;
            else if (op == 3) m_ccr[2] = 1'b0;
            else if (op >= 20 && op <= 22) begin
                idx = 2'(op - 20);
                if (m_ccr[idx]) begin
                    m_jump     = 1'b1;
                    m_ccr[idx] = 1'b0;
                end
            end else if (op == 26) begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else m_ccr = m_stack.pop_back();
            end else if (op == 27) begin
                m_ccr = 3'b000;
                m_stack.delete();
            end else if (we) m_ccr = f;
        end
        m_phase = nphase;
    endtask

    task automatic drive(input logic v, input int op, input logic [2:0] f,
                         input logic we, input logic req);
        valid_i        = v;
        alu_op_i       = 5'(op);
        alu_flags_i    = f;
        alu_flags_we_i = we;
        int_req_i      = req;
        model_step(v, op, f, we, req);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic interrupt();
        drive(1'b0, 0, 3'b000, 1'b0, 1'b1);
        drive(1'b0, 0, 3'b000, 1'b0, 1'b1);
        drive(1'b0, 0, 3'b000, 1'b0, 1'b1);
        idle();
    endtask

    task automatic do_reset();
        valid_i = 1'b0; alu_op_i = '0; alu_flags_i = '0; alu_flags_we_i = 1'b0; int_req_i = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        valid_i = 1'b0; alu_op_i = '0; alu_flags_i = '0; alu_flags_we_i = 1'b0; int_req_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ccr_o, jump_taken_o, stall_o, int_ack_o, err_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ccr=%b jump=%b stall=%b ack=%b err=%b, expected all 0",
                     ccr_o, jump_taken_o, stall_o, int_ack_o, err_o);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_branch();
        drive(1'b1, 0, 3'b001, 1'b1, 1'b0);
        n_cmp++;
        if (ccr_o !== 3'b001) begin n_fail++; $display("FAIL alu_update: ccr=%b expected 001", ccr_o); end
        drive(1'b1, 20, 3'b000, 1'b0, 1'b0);
        n_cmp++;
        if (jump_taken_o !== 1'b1) begin n_fail++; $display("FAIL jz_taken: jump=%b expected 1", jump_taken_o); end
        n_cmp++;
        if (ccr_o !== 3'b000) begin n_fail++; $display("FAIL jz_clear: ccr=%b expected 000", ccr_o); end
        idle();
        n_cmp++;
        if (jump_taken_o !== 1'b0) begin n_fail++; $display("FAIL jump_idle: jump=%b expected 0", jump_taken_o); end
        drive(1'b1, 22, 3'b111, 1'b1, 1'b0);
        n_cmp++;
        if ({jump_taken_o, ccr_o} !== 4'b0000) begin
            n_fail++; $display("FAIL jc_not_taken: jump=%b ccr=%b expected 0/000", jump_taken_o, ccr_o);
        end
        drive(1'b1, 2, 3'b000, 1'b1, 1'b0);
        n_cmp++;
        if (ccr_o !== 3'b100) begin n_fail++; $display("FAIL setc: ccr=%b expected 100", ccr_o); end
        drive(1'b1, 22, 3'b000, 1'b0, 1'b0);
        n_cmp++;
        if ({jump_taken_o, ccr_o} !== 4'b1000) begin
            n_fail++; $display("FAIL jc_taken: jump=%b ccr=%b expected 1/000", jump_taken_o, ccr_o);
        end
    endtask

    task automatic test_interrupt();
        drive(1'b1, 0, 3'b110, 1'b1, 1'b0);
        drive(1'b0, 0, 3'b000, 1'b0, 1'b1);
        n_cmp++;
        if ({stall_o, int_ack_o} !== 2'b10) begin
            n_fail++; $display("FAIL int_drain: stall=%b ack=%b expected 1/0", stall_o, int_ack_o);
        end
        drive(1'b1, 2, 3'b000, 1'b0, 1'b1);
        n_cmp++;
        if ({stall_o, int_ack_o, ccr_o} !== 5'b10110) begin
            n_fail++; $display("FAIL int_stall_ignore: stall=%b ack=%b ccr=%b expected 1/0/110",
                               stall_o, int_ack_o, ccr_o);
        end
        drive(1'b0, 0, 3'b000, 1'b0, 1'b1);
        n_cmp++;
        if ({stall_o, int_ack_o, ccr_o} !== 5'b11000) begin
            n_fail++; $display("FAIL int_ack: stall=%b ack=%b ccr=%b expected 1/1/000",
                               stall_o, int_ack_o, ccr_o);
        end
        idle();
        n_cmp++;
        if ({stall_o, int_ack_o} !== 2'b00) begin
            n_fail++; $display("FAIL int_done: stall=%b ack=%b expected 0/0", stall_o, int_ack_o);
        end
        drive(1'b1, 26, 3'b000, 1'b0, 1'b0);
        n_cmp++;
        if (ccr_o !== 3'b110) begin n_fail++; $display("FAIL rti_restore: ccr=%b expected 110", ccr_o); end
    endtask

    task automatic test_nested();
        logic [2:0] exp;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 0, 3'(i), 1'b1, 1'b0);
            interrupt();
            n_cmp++;
            if (err_o !== (i == 5)) begin
                n_fail++; $display("FAIL nest_err_%0d: err=%b expected %b", i, err_o, (i == 5));
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 26, 3'b000, 1'b0, 1'b0);
            exp = 3'(4 - k);
            n_cmp++;
            if (ccr_o !== exp) begin n_fail++; $display("FAIL nest_rti_%0d: ccr=%b expected %b", k, ccr_o, exp); end
        end
        drive(1'b1, 26, 3'b000, 1'b0, 1'b0);
        n_cmp++;
        if ({ccr_o, err_o} !== 4'b0011) begin
            n_fail++; $display("FAIL nest_rti_empty: ccr=%b err=%b expected 001/1", ccr_o, err_o);
        end
    endtask

    task automatic test_rti_race();
        do_reset();
        drive(1'b1, 0, 3'b101, 1'b1, 1'b0);
        interrupt();
        drive(1'b1, 0, 3'b010, 1'b1, 1'b0);
        drive(1'b1, 26, 3'b000, 1'b0, 1'b1);
        n_cmp++;
        if ({ccr_o, stall_o} !== 4'b1011) begin
            n_fail++; $display("FAIL race_pop_first: ccr=%b stall=%b expected 101/1", ccr_o, stall_o);
        end
        drive(1'b0, 0, 3'b000, 1'b0, 1'b1);
        drive(1'b0, 0, 3'b000, 1'b0, 1'b1);
        idle();
        drive(1'b1, 26, 3'b000, 1'b0, 1'b0);
        n_cmp++;
        if ({ccr_o, err_o} !== 4'b1010) begin
            n_fail++; $display("FAIL race_saved_value: ccr=%b err=%b expected 101/0", ccr_o, err_o);
        end
        drive(1'b1, 26, 3'b000, 1'b0, 1'b0);
        n_cmp++;
        if ({ccr_o, err_o} !== 4'b1011) begin
            n_fail++; $display("FAIL race_stack_empty: ccr=%b err=%b expected 101/1", ccr_o, err_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 0, 3'b111, 1'b1, 1'b0);
        drive(1'b0, 0, 3'b000, 1'b0, 1'b1);
        drive(1'b0, 0, 3'b000, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({ccr_o, jump_taken_o, stall_o, int_ack_o, err_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid_save: ccr=%b jump=%b stall=%b ack=%b err=%b expected all 0",
                     ccr_o, jump_taken_o, stall_o, int_ack_o, err_o);
        end
        model_reset();
        int_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        n_cmp++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_idle: stall=%b expected 0", stall_o); end
        drive(1'b1, 26, 3'b000, 1'b0, 1'b0);
        n_cmp++;
        if ({ccr_o, err_o} !== 4'b0001) begin
            n_fail++; $display("FAIL reset_mid_empty: ccr=%b err=%b expected 000/1", ccr_o, err_o);
        end
    endtask

    task automatic test_random();
        logic       req;
        logic       v;
        int         op;
        int         sel;
        do_reset();
        req = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (m_phase == 3) req = 1'b0;
            else if (!req && $urandom_range(0, 15) == 0) req = 1'b1;
            sel = $urandom_range(0, 11);
            case (sel)
                0: op = 2;
                1: op = 3;
                2: op = 20;
                3: op = 21;
                4: op = 22;
                5: op = 26;
                6: op = ($urandom_range(0, 3) == 0) ? 27 : 0;
                default: op = $urandom_range(0, 31);
            endcase
            v = ($urandom_range(0, 3) != 0);
            drive(v, op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), req);
            n_cmp++;
            if (ccr_o !== m_ccr) begin
                n_fail++; $display("FAIL rand_ccr c=%0d: ccr=%b expected %b", c, ccr_o, m_ccr);
            end
            n_cmp++;
            if (jump_taken_o !== m_jump) begin
                n_fail++; $display("FAIL rand_jump c=%0d: jump=%b expected %b", c, jump_taken_o, m_jump);
            end
            n_cmp++;
            if (stall_o !== (m_phase != 0)) begin
                n_fail++; $display("FAIL rand_stall c=%0d: stall=%b expected %b", c, stall_o, (m_phase != 0));
            end
            n_cmp++;
            if (int_ack_o !== (m_phase == 3)) begin
                n_fail++; $display("FAIL rand_ack c=%0d: ack=%b expected %b", c, int_ack_o, (m_phase == 3));
            end
            n_cmp++;
            if (err_o !== m_err) begin
                n_fail++; $display("FAIL rand_err c=%0d: err=%b expected %b", c, err_o, m_err);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_branch();
        test_interrupt();
        test_nested();
        test_rti_race();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
